spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter NumberOfSlaves, default 1: number of slave-select lines; must be >= 1.
REQ-002 SHALL have parameter DataWidth, default 8: bits per transfer frame; must be >= 1.
REQ-003 SHALL have parameter ClkDiv, default 4: system cycles per sclk half-period; must be >= 2.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Clock port: clk, input, 1 bit; system clock, all logic on its rising edge.
REQ-006 Reset port: rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-007 req_valid, input, 1 bit: transfer request present.
REQ-008 req_ready, output, 1 bit: controller can accept a request.
REQ-009 req_slave, input, $clog2(NumberOfSlaves) bits (min 1): target slave index.
REQ-010 req_data, input, DataWidth bits: frame to transmit, MSB first.
REQ-011 rsp_valid, output, 1 bit: one-cycle pulse, transfer complete.
REQ-012 rsp_data, output, DataWidth bits: frame received from the slave, valid with rsp_valid.
REQ-013 rsp_err, output, 1 bit: qualifies rsp_valid; request targeted an out-of-range slave index.
REQ-014 busy, output, 1 bit: high in every state except IDLE.
REQ-015 spi, Spi.MasterSpi modport with NumberOfSlaves: drives sclk, mosi and nss, and samples miso.

Function
REQ-016 SHALL implement SPI mode 0: CPOL=0, CPHA=0; sample miso[sel] on the sclk rising edge; update mosi on the sclk falling edge.
REQ-017 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD.
REQ-018 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid && req_ready; on handshake, latch req_slave and req_data and go to SETUP.
REQ-019 SETUP SHALL last ClkDiv cycles, with nss[sel]=0, sclk=0 and mosi=frame MSB, then go to SHIFT.
REQ-020 SHIFT SHALL run 2*DataWidth half-periods of ClkDiv cycles each, starting with sclk rising; it ends after the final falling edge, with sclk=0.
REQ-021 In SHIFT, each rising edge SHALL shift miso[sel] into the receive register LSB, and each falling edge except the last SHALL present the next tx bit on mosi.
REQ-022 On SHIFT->HOLD, for exactly one cycle: rsp_valid=1 and rsp_data=received frame; in the same cycle nss becomes all-ones.
REQ-023 HOLD SHALL last ClkDiv cycles with nss all-ones, then go to IDLE.
REQ-024 Latency SHALL be: handshake at cycle 0 -> rsp_valid at cycle ClkDiv*(1+2*DataWidth) -> req_ready again ClkDiv cycles later.
REQ-025 For req_slave >= NumberOfSlaves, the full timing SHALL run with nss kept all-ones, rsp_data all-ones and rsp_err=1 alongside rsp_valid.
REQ-026 At most one nss bit SHALL be low at any time, so the one-hot slave-select rule always holds.
REQ-027 Changes to req_* after the handshake SHALL be ignored until the next IDLE.
REQ-028 req_valid deasserting in IDLE without a handshake SHALL have no effect.
REQ-029 rsp_data SHALL hold its value until the next rsp_valid.
REQ-030 Outside IDLE, mosi SHALL be driven from the register; in IDLE, mosi=0.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, sclk=0, mosi=0, nss all-ones, req_ready=1 (after the first clk edge with rst_n=1), rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, counters=0.
REQ-032 Reset mid-transfer SHALL abort the transfer with no rsp_valid, and nss SHALL deassert immediately.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum and the default DataWidth and ClkDiv constants.
REQ-034 Sub-module spi_clk_gen SHALL be the natural half-period tick counter (enable, tick output), reset with the controller.

Verification
REQ-035 DataWidth=8, ClkDiv=4, slave 0, req_data=8'hA5, slave loopback returns 8'h3C -> mosi bits 1,0,1,0,0,1,0,1 on rising edges; rsp_valid at cycle 68; rsp_data=8'h3C; req_ready at cycle 72.
REQ-036 NumberOfSlaves=4, req_slave=2 -> only nss[2] low during SETUP+SHIFT; nss=4'b1111 otherwise; one-hot assertion never fires.
REQ-037 req_slave=5 with NumberOfSlaves=4 -> nss stays 4'b1111; rsp_valid with rsp_err=1 and rsp_data=8'hFF at cycle 68.
REQ-038 Back-to-back requests with req_valid held high -> second handshake exactly at cycle 72; 4 sclk-low cycles with nss high between frames.
REQ-039 rst_n pulled low at cycle 30 of a transfer -> same cycle: nss all-ones, sclk=0; no rsp_valid; next request completes normally.
REQ-040 req_data changed during SHIFT -> transmitted frame unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared FSM state type and default frame/clock parameters for the SPI master controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultClkDiv    = 4;

endpackage

// File: rtl/spi_if.sv
// SPI bus bundle: one shared sclk/mosi, per-slave active-low select and per-slave miso.
interface Spi #(
    parameter int unsigned NumberOfSlaves = 1
);
    logic                      sclk;
    logic                      mosi;
    logic [NumberOfSlaves-1:0] nss;
    logic [NumberOfSlaves-1:0] miso;

    modport MasterSpi (output sclk, output mosi, output nss, input miso);
    modport SlaveSpi  (input sclk, input mosi, input nss, output miso);
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: while enabled, tick is high on the last cycle of every ClkDiv-cycle period.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned ClkDiv = DefaultClkDiv
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int unsigned CntW = $clog2(ClkDiv);

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntW'(ClkDiv - 1));

    // Period counter: held at zero while disabled so every enable starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one request/response handshake per frame, MSB first, one-hot slave select.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned NumberOfSlaves = 1,
    parameter int unsigned DataWidth      = DefaultDataWidth,
    parameter int unsigned ClkDiv         = DefaultClkDiv,
    localparam int unsigned SelW          = (NumberOfSlaves > 1) ? $clog2(NumberOfSlaves) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SelW-1:0]      req_slave,
    input  logic [DataWidth-1:0] req_data,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    Spi.MasterSpi                spi
);
    localparam int unsigned HcW = $clog2(2 * DataWidth + 1);

    spi_state_t                state_q, state_d;
    logic                      tick;
    logic                      sclk_q, mosi_q, err_q, rsp_valid_q;
    logic [NumberOfSlaves-1:0] nss_q, sel_mask;
    logic [DataWidth-1:0]      tx_q, rx_q, rsp_data_q, tx_shift, rx_shift;
    logic [HcW-1:0]            hcnt_q;
    logic                      sel_err, miso_bit, last_half, last_fall;

    spi_clk_gen #(.ClkDiv(ClkDiv)) u_clk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .tick (tick)
    );

    assign sel_err   = 32'(req_slave) >= NumberOfSlaves;
    assign sel_mask  = sel_err ? '1 : ~(NumberOfSlaves'(1) << req_slave);
    // Only the selected line is low, so this picks its miso (and reads 0 on an out-of-range request).
    assign miso_bit  = |(spi.miso & ~nss_q);
    assign rx_shift  = DataWidth'({rx_q, miso_bit});
    assign tx_shift  = tx_q << 1;
    assign last_half = (hcnt_q == HcW'(2 * DataWidth));
    assign last_fall = (hcnt_q == HcW'(2 * DataWidth - 1));

    assign spi.sclk  = sclk_q;
    assign spi.mosi  = busy & mosi_q;
    assign spi.nss   = nss_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_valid_q & err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; each timed phase advances on the half-period tick.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = SETUP;
            end
            SETUP:   if (tick) state_d = SHIFT;
            SHIFT:   if (tick && last_half) state_d = HOLD;
            HOLD:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch on handshake, toggle sclk per half-period, sample on rise, shift mosi on fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            nss_q       <= '1;
            err_q       <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            hcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    tx_q   <= req_data;
                    mosi_q <= req_data[DataWidth-1];
                    nss_q  <= sel_mask;
                    err_q  <= sel_err;
                    rx_q   <= '0;
                    hcnt_q <= '0;
                end
                // First rising edge coincides with the SETUP->SHIFT transition.
                SETUP: if (tick) begin
                    sclk_q <= 1'b1;
                    rx_q   <= rx_shift;
                    hcnt_q <= HcW'(1);
                end
                SHIFT: if (tick) begin
                    if (last_half) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= err_q ? '1 : rx_q;
                        nss_q       <= '1;
                    end else begin
                        sclk_q <= ~sclk_q;
                        hcnt_q <= hcnt_q + HcW'(1);
                        if (!sclk_q) begin
                            rx_q <= rx_shift;
                        end else if (!last_fall) begin
                            tx_q   <= tx_shift;
                            mosi_q <= tx_shift[DataWidth-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench: two controllers (4 and 3 slaves) share one request stream; loopback slaves reply.
module tb_spi_master_ctrl;
    localparam int unsigned DW      = 8;
    localparam int unsigned CDIV    = 4;
    localparam int unsigned LAT     = CDIV * (1 + 2 * DW);
    localparam int unsigned READY_T = LAT + CDIV;

    typedef struct { logic [7:0] data; logic err; int unsigned hs; int unsigned lows; } rsp_exp_t;
    typedef struct { int unsigned slave; logic [7:0] data; } tx_exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_slave = '0;
    logic [7:0] req_data  = '0;
    logic [7:0] reply     = '0;

    logic       ready_a, rv_a, err_a, busy_a, ready_b, rv_b, err_b, busy_b;
    logic [7:0] rd_a, rd_b;
    logic [3:0] miso_a;
    logic [2:0] miso_b;

    int unsigned n_checks = 0, n_errors = 0, edge_n = 0;
    rsp_exp_t rq0[$], rq1[$];
    tx_exp_t  tq0[$], tq1[$];
    int unsigned low_cnt[2], last_hs[2];
    bit          bad[2], hs_pend[2];
    logic        prev_ready[2];
    logic [3:0]  exp_mask[2];
    logic [7:0]  last_data[2];

    Spi #(.NumberOfSlaves(4)) spi_a ();
    Spi #(.NumberOfSlaves(3)) spi_b ();
    assign spi_a.miso = miso_a;
    assign spi_b.miso = miso_b;

    spi_master_ctrl #(.NumberOfSlaves(4), .DataWidth(DW), .ClkDiv(CDIV)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_slave(req_slave), .req_data(req_data), .rsp_valid(rv_a), .rsp_data(rd_a),
        .rsp_err(err_a), .busy(busy_a), .spi(spi_a)
    );

    spi_master_ctrl #(.NumberOfSlaves(3), .DataWidth(DW), .ClkDiv(CDIV)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
        .req_slave(req_slave), .req_data(req_data), .rsp_valid(rv_b), .rsp_data(rd_b),
        .rsp_err(err_b), .busy(busy_b), .spi(spi_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called by a slave model when its select deasserts: compare the frame it shifted in.
    task automatic slave_done(input int d, input int unsigned g, input logic [7:0] cap, input int unsigned nb);
        tx_exp_t e;
        if ((d == 0 && tq0.size() == 0) || (d == 1 && tq1.size() == 0)) begin
            check("tx_unexpected", 32'd1, 32'd0);
            return;
        end
        if (d == 0) e = tq0.pop_front();
        else        e = tq1.pop_front();
        check("tx_slave", g, e.slave);
        check("tx_frame", cap, e.data);
        check("tx_bits", nb, DW);
    endtask

    // Loopback slaves: present reply MSB first, change miso on sclk fall, capture mosi on sclk rise.
    for (genvar g = 0; g < 4; g++) begin : g_slave_a
        logic [7:0] sh = '0, cap = '0;
        int unsigned nb = 0;
        logic m = 1'b0;
        assign miso_a[g] = m;
        always @(negedge spi_a.nss[g]) begin sh = reply; m = reply[7]; cap = '0; nb = 0; end
        always @(negedge spi_a.sclk) if (!spi_a.nss[g]) begin sh = sh << 1; m = sh[7]; end
        always @(posedge spi_a.sclk) if (!spi_a.nss[g]) begin cap = {cap[6:0], spi_a.mosi}; nb++; end
        always @(posedge spi_a.nss[g]) if (rst_n) slave_done(0, g, cap, nb);
    end

    for (genvar g = 0; g < 3; g++) begin : g_slave_b
        logic [7:0] sh = '0, cap = '0;
        int unsigned nb = 0;
        logic m = 1'b0;
        assign miso_b[g] = m;
        always @(negedge spi_b.nss[g]) begin sh = reply; m = reply[7]; cap = '0; nb = 0; end
        always @(negedge spi_b.sclk) if (!spi_b.nss[g]) begin sh = sh << 1; m = sh[7]; end
        always @(posedge spi_b.sclk) if (!spi_b.nss[g]) begin cap = {cap[6:0], spi_b.mosi}; nb++; end
        always @(posedge spi_b.nss[g]) if (rst_n) slave_done(1, g, cap, nb);
    end

    task automatic observe(input int d, input logic [3:0] nss, input logic busy, input logic ready,
                           input logic rv, input logic [7:0] rd, input logic re);
        rsp_exp_t e;
        if (busy) begin
            check("nss_onehot", 32'($countones(~nss) <= 1), 32'd1);
            if (nss != 4'hF) begin
                low_cnt[d]++;
                if (nss != exp_mask[d]) bad[d] = 1'b1;
            end
        end
        if (rv) begin
            if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                if (d == 0) e = rq0.pop_front();
                else        e = rq1.pop_front();
                check("rsp_data", rd, e.data);
                check("rsp_err", re, e.err);
                check("rsp_latency", edge_n - 1 - e.hs, LAT);
                check("nss_low_cycles", low_cnt[d], e.lows);
                check("nss_wrong_line", bad[d], 0);
                last_data[d] = e.data;
            end
        end
        if (ready && !prev_ready[d] && hs_pend[d]) begin
            check("ready_latency", edge_n - 1 - last_hs[d], READY_T);
            hs_pend[d] = 1'b0;
        end
        prev_ready[d] = ready;
    endtask

    // Monitor: sample both controllers away from the active edge.
    always @(negedge clk) if (rst_n) begin
        observe(0, spi_a.nss, busy_a, ready_a, rv_a, rd_a, err_a);
        observe(1, {1'b1, spi_b.nss}, busy_b, ready_b, rv_b, rd_b, err_b);
    end

    // Issue one request; on handshake push the expected responses for both controllers.
    task automatic do_xfer(input int unsigned slave, input logic [7:0] data, input logic [7:0] rep, input bit hold);
        bit got = 1'b0;
        bit b2b;
        bit e_b;
        @(negedge clk);
        check("rsp_hold", rd_a, last_data[0]);
        b2b       = req_valid;
        req_slave = 2'(slave);
        req_data  = data;
        reply     = rep;
        req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (ready_a) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("handshake_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (b2b) check("b2b_gap", edge_n - last_hs[0], READY_T + 1);
        e_b = (slave >= 3);
        rq0.push_back('{rep, 1'b0, edge_n, LAT});
        tq0.push_back('{slave, data});
        rq1.push_back('{e_b ? 8'hFF : rep, e_b, edge_n, e_b ? 0 : LAT});
        if (!e_b) tq1.push_back('{slave, data});
        for (int d = 0; d < 2; d++) begin
            last_hs[d] = edge_n; hs_pend[d] = 1'b1; low_cnt[d] = 0; bad[d] = 1'b0;
        end
        exp_mask[0] = ~(4'b0001 << slave);
        exp_mask[1] = e_b ? 4'hF : ~(4'b0001 << slave);
        #1;
        req_valid = hold;
        req_data  = 8'($urandom);
        req_slave = 2'($urandom);
    endtask

    initial begin
        last_data[0] = '0; last_data[1] = '0;
        prev_ready[0] = 1'b1; prev_ready[1] = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check("rst_nss_a", spi_a.nss, 4'hF);
        check("rst_nss_b", spi_b.nss, 3'h7);
        check("rst_sclk", spi_a.sclk, 0);
        check("rst_mosi", spi_a.mosi, 0);
        check("rst_rsp_valid", rv_a, 0);
        check("rst_rsp_err", err_a, 0);
        check("rst_rsp_data", rd_a, 0);
        check("rst_busy", busy_a, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready_a, 1);

        do_xfer(0, 8'hA5, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        do_xfer(2, 8'h5A, 8'hC3, 1'b0);
        do_xfer(3, 8'h81, 8'h7E, 1'b0);
        do_xfer(1, 8'h0F, 8'hF0, 1'b1);
        do_xfer(2, 8'hFF, 8'h00, 1'b1);
        do_xfer(3, 8'h00, 8'hFF, 1'b0);

        for (int n = 0; n < 16; n++) begin
            bit h = ($urandom_range(0, 2) == 0);
            do_xfer($urandom_range(0, 3), 8'($urandom), 8'($urandom), h);
            if (!h) repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Abort mid-transfer with an asynchronous reset, then confirm a clean restart.
        do_xfer(1, 8'h96, 8'h69, 1'b0);
        repeat (29) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_nss_a", spi_a.nss, 4'hF);
        check("abort_nss_b", spi_b.nss, 3'h7);
        check("abort_sclk", spi_a.sclk, 0);
        check("abort_busy", busy_a, 0);
        check("abort_rsp_valid", rv_a, 0);
        rq0.delete(); rq1.delete(); tq0.delete(); tq1.delete();
        hs_pend[0] = 1'b0; hs_pend[1] = 1'b0;
        last_data[0] = '0; last_data[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        do_xfer(2, 8'hC6, 8'h5B, 1'b0);

        for (int i = 0; i < 400 && (rq0.size() != 0 || rq1.size() != 0); i++) @(negedge clk);
        repeat (CDIV + 2) @(negedge clk);
        check("drain_a", rq0.size(), 0);
        check("drain_b", rq1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
